// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 pixel sink: ILI9341 opcodes, init parameter
// bytes, FSM encodings and the bus word record.
package lt24_pkg;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] CMD_MADCTL = 8'h36;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_PASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam logic [7:0] COLMOD_RGB565 = 8'h55;
    localparam logic [7:0] MADCTL_VALUE  = 8'h48;

    localparam logic [3:0] WINDOW_WORDS = 4'd12;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_SLPOUT,
        ST_SLP_WAIT,
        ST_CFG,
        ST_IDLE,
        ST_PIXEL
    } sinkState_t;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_LOW,
        BW_HIGH
    } busPhase_t;

    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } busWord_t;

    function automatic busWord_t cmdWord(input logic [7:0] code);
        busWord_t w;
        w.rs   = 1'b0;
        w.data = {8'h00, code};
        return w;
    endfunction

    function automatic busWord_t dataWord(input logic [15:0] value);
        busWord_t w;
        w.rs   = 1'b1;
        w.data = value;
        return w;
    endfunction

endpackage

// File: rtl/lt24_pixel_sink_if.sv
// Pixel-write handshake between the maze renderer (master) and the LT24 sink (slave).
interface lt24_pixel_sink_if;

    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (
        output xAddr,
        output yAddr,
        output pixelData,
        output pixelWrite,
        input  pixelReady
    );

    modport slave (
        input  xAddr,
        input  yAddr,
        input  pixelData,
        input  pixelWrite,
        output pixelReady
    );

endinterface

// File: rtl/lt24_bus_word.sv
// One 8080-style write: WRn low for LOW_CYCLES then high for HIGH_CYCLES with RS/D
// held throughout; o_done marks the last high clock so a back-to-back start can follow.
module lt24_bus_word
    import lt24_pkg::*;
#(
    parameter int LOW_CYCLES  = 2,
    parameter int HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetApp,
    input  logic        i_start,
    input  logic        i_rs,
    input  logic [15:0] i_data,
    output logic        o_done,
    output logic        o_idle,
    output logic        o_wrn,
    output logic        o_rs,
    output logic [15:0] o_d
);

    localparam int CW = 8;

    busPhase_t   r_phase;
    logic [CW-1:0] r_cnt;
    logic        r_wrn;
    logic        r_rs;
    logic [15:0] r_d;
    logic        w_accept;

    assign o_done   = (r_phase == BW_HIGH) && (r_cnt == CW'(HIGH_CYCLES - 1));
    assign o_idle   = (r_phase == BW_IDLE);
    assign w_accept = i_start && (o_idle || o_done);
    assign o_wrn    = r_wrn;
    assign o_rs     = r_rs;
    assign o_d      = r_d;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            r_phase <= BW_IDLE;
            r_cnt   <= '0;
            r_wrn   <= 1'b1;
            r_rs    <= 1'b1;
            r_d     <= 16'h0000;
        end else if (w_accept) begin
            r_phase <= BW_LOW;
            r_cnt   <= '0;
            r_wrn   <= 1'b0;
            r_rs    <= i_rs;
            r_d     <= i_data;
        end else begin
            case (r_phase)
                BW_LOW: begin
                    if (r_cnt == CW'(LOW_CYCLES - 1)) begin
                        r_phase <= BW_HIGH;
                        r_cnt   <= '0;
                        r_wrn   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BW_HIGH: begin
                    if (o_done) begin
                        r_phase <= BW_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lt24_pixel_sink.sv
// LT24 (ILI9341) pixel sink: resets and initialises the panel, then turns each accepted
// pixel into bus writes, re-programming the window only when auto-increment cannot reach it.
module lt24_pixel_sink
    import lt24_pkg::*;
#(
    parameter int WIDTH             = 240,
    parameter int HEIGHT            = 320,
    parameter int WR_LOW_CYCLES     = 2,
    parameter int WR_HIGH_CYCLES    = 2,
    parameter int RESET_CYCLES      = 500000,
    parameter int RESET_WAIT_CYCLES = 6000000,
    parameter int SLEEP_WAIT_CYCLES = 6000000
) (
    input  logic                clock,
    input  logic                resetApp,
    lt24_pixel_sink_if.slave    pix,
    output logic                initDone,
    output logic                LT24_WRn,
    output logic                LT24_RDn,
    output logic                LT24_CSn,
    output logic                LT24_RS,
    output logic                LT24_RESETn,
    output logic [15:0]         LT24_D,
    output logic                LT24_LCD_ON
);

    localparam logic [8:0] EC = 9'(WIDTH - 1);
    localparam logic [8:0] EP = 9'(HEIGHT - 1);

    sinkState_t  r_state;
    sinkState_t  w_nextState;
    logic [31:0] r_waitCnt;
    logic [3:0]  r_wordIdx;
    logic [3:0]  r_wordCount;
    logic [3:0]  w_wordCount;
    logic [7:0]  r_x;
    logic [8:0]  r_y;
    logic [15:0] r_pixel;
    logic [7:0]  r_nextX;
    logic [8:0]  r_nextY;
    logic [7:0]  r_winX;
    logic [8:0]  r_winY;
    logic        r_addrValid;

    busWord_t    w_word;
    logic        w_issue;
    logic        w_wordsDone;
    logic        w_busDone;
    logic        w_busIdle;
    logic        w_accept;
    logic        w_outOfRange;
    logic        w_sequential;
    logic [7:0]  w_winX;
    logic [8:0]  w_winY;
    logic [7:0]  w_succX;
    logic [8:0]  w_succY;

    lt24_bus_word #(
        .LOW_CYCLES  (WR_LOW_CYCLES),
        .HIGH_CYCLES (WR_HIGH_CYCLES)
    ) u_busWord (
        .clock    (clock),
        .resetApp (resetApp),
        .i_start  (w_issue),
        .i_rs     (w_word.rs),
        .i_data   (w_word.data),
        .o_done   (w_busDone),
        .o_idle   (w_busIdle),
        .o_wrn    (LT24_WRn),
        .o_rs     (LT24_RS),
        .o_d      (LT24_D)
    );

    assign w_accept    = (r_state == ST_IDLE) && pix.pixelWrite;
    assign w_issue     = (r_wordIdx < w_wordCount) && (w_busIdle || w_busDone);
    assign w_wordsDone = (r_wordIdx == w_wordCount) && ((w_wordCount == 4'd0) || w_busDone);

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            r_state <= ST_RST_LOW;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RST_LOW:  if (r_waitCnt == 32'(RESET_CYCLES - 1))      w_nextState = ST_RST_WAIT;
            ST_RST_WAIT: if (r_waitCnt == 32'(RESET_WAIT_CYCLES - 1)) w_nextState = ST_SLPOUT;
            ST_SLPOUT:   if (w_wordsDone)                             w_nextState = ST_SLP_WAIT;
            ST_SLP_WAIT: if (r_waitCnt == 32'(SLEEP_WAIT_CYCLES - 1)) w_nextState = ST_CFG;
            ST_CFG:      if (w_wordsDone)                             w_nextState = ST_IDLE;
            ST_IDLE:     if (w_accept)                                w_nextState = ST_PIXEL;
            ST_PIXEL:    if (w_wordsDone)                             w_nextState = ST_IDLE;
            default:                                                  w_nextState = ST_RST_LOW;
        endcase
    end

    always_comb begin
        pix.pixelReady = (r_state == ST_IDLE);
        initDone       = (r_state == ST_IDLE) || (r_state == ST_PIXEL);
        LT24_LCD_ON    = initDone;
        LT24_RESETn    = (r_state != ST_RST_LOW);
        LT24_CSn       = (r_state == ST_RST_LOW);
        LT24_RDn       = 1'b1;
        w_wordCount    = 4'd0;
        w_word         = cmdWord(CMD_SLPOUT);
        case (r_state)
            ST_SLPOUT: begin
                w_wordCount = 4'd1;
                w_word      = cmdWord(CMD_SLPOUT);
            end
            ST_CFG: begin
                w_wordCount = 4'd5;
                case (r_wordIdx)
                    4'd0:    w_word = cmdWord(CMD_COLMOD);
                    4'd1:    w_word = dataWord({8'h00, COLMOD_RGB565});
                    4'd2:    w_word = cmdWord(CMD_MADCTL);
                    4'd3:    w_word = dataWord({8'h00, MADCTL_VALUE});
                    default: w_word = cmdWord(CMD_DISPON);
                endcase
            end
            ST_PIXEL: begin
                w_wordCount = r_wordCount;
                if (r_wordCount == 4'd1) begin
                    w_word = dataWord(r_pixel);
                end else begin
                    case (r_wordIdx)
                        4'd0:    w_word = cmdWord(CMD_CASET);
                        4'd1:    w_word = dataWord(16'h0000);
                        4'd2:    w_word = dataWord({8'h00, r_x});
                        4'd3:    w_word = dataWord({15'h0000, EC[8]});
                        4'd4:    w_word = dataWord({8'h00, EC[7:0]});
                        4'd5:    w_word = cmdWord(CMD_PASET);
                        4'd6:    w_word = dataWord({15'h0000, r_y[8]});
                        4'd7:    w_word = dataWord({8'h00, r_y[7:0]});
                        4'd8:    w_word = dataWord({15'h0000, EP[8]});
                        4'd9:    w_word = dataWord({8'h00, EP[7:0]});
                        4'd10:   w_word = cmdWord(CMD_RAMWR);
                        default: w_word = dataWord(r_pixel);
                    endcase
                end
            end
            default: ;
        endcase
    end

    // The successor follows the panel's auto-increment: right along the row, then back
    // to the window's start column on the next row, then back to the window origin.
    always_comb begin
        w_outOfRange = ({1'b0, pix.xAddr} > EC) || (pix.yAddr > EP);
        w_sequential = r_addrValid && (pix.xAddr == r_nextX) && (pix.yAddr == r_nextY);
        w_winX       = w_sequential ? r_winX : pix.xAddr;
        w_winY       = w_sequential ? r_winY : pix.yAddr;
        if ({1'b0, pix.xAddr} < EC) begin
            w_succX = pix.xAddr + 8'd1;
            w_succY = pix.yAddr;
        end else if (pix.yAddr < EP) begin
            w_succX = w_winX;
            w_succY = pix.yAddr + 9'd1;
        end else begin
            w_succX = w_winX;
            w_succY = w_winY;
        end
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            r_waitCnt   <= '0;
            r_wordIdx   <= '0;
            r_wordCount <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_pixel     <= '0;
            r_nextX     <= '0;
            r_nextY     <= '0;
            r_winX      <= '0;
            r_winY      <= '0;
            r_addrValid <= 1'b0;
        end else begin
            if (w_nextState != r_state) begin
                r_waitCnt <= '0;
                r_wordIdx <= '0;
            end else begin
                if ((r_state == ST_RST_LOW) || (r_state == ST_RST_WAIT) || (r_state == ST_SLP_WAIT)) begin
                    r_waitCnt <= r_waitCnt + 32'd1;
                end
                if (w_issue) begin
                    r_wordIdx <= r_wordIdx + 4'd1;
                end
            end
            if ((r_state != ST_IDLE) && (r_state != ST_PIXEL)) begin
                r_addrValid <= 1'b0;
            end
            if (w_accept) begin
                r_x     <= pix.xAddr;
                r_y     <= pix.yAddr;
                r_pixel <= pix.pixelData;
                if (w_outOfRange) begin
                    r_wordCount <= 4'd0;
                end else begin
                    r_wordCount <= w_sequential ? 4'd1 : WINDOW_WORDS;
                    r_winX      <= w_winX;
                    r_winY      <= w_winY;
                    r_nextX     <= w_succX;
                    r_nextY     <= w_succY;
                    r_addrValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lt24_pixel_sink.sv
// Directed bench for lt24_pixel_sink: reset/init trace, window and sequential pixels,
// row/frame wrap, busy and out-of-range handling, reset during a transaction.
module tb_lt24_pixel_sink;

    logic        clock = 1'b0;
    logic        resetApp = 1'b1;
    logic        initDone;
    logic        LT24_WRn;
    logic        LT24_RDn;
    logic        LT24_CSn;
    logic        LT24_RS;
    logic        LT24_RESETn;
    logic [15:0] LT24_D;
    logic        LT24_LCD_ON;

    int checks = 0;
    int failures = 0;

    logic [16:0] words[$];
    logic        prevWrn = 1'b1;
    logic [16:0] expWords[12];
    logic [16:0] initWords[6] = '{17'h00011, 17'h0003A, 17'h10055, 17'h00036, 17'h10048, 17'h00029};

    lt24_pixel_sink_if pixIf ();

    lt24_pixel_sink #(
        .WIDTH             (240),
        .HEIGHT            (320),
        .WR_LOW_CYCLES     (2),
        .WR_HIGH_CYCLES    (2),
        .RESET_CYCLES      (4),
        .RESET_WAIT_CYCLES (8),
        .SLEEP_WAIT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .resetApp    (resetApp),
        .pix         (pixIf),
        .initDone    (initDone),
        .LT24_WRn    (LT24_WRn),
        .LT24_RDn    (LT24_RDn),
        .LT24_CSn    (LT24_CSn),
        .LT24_RS     (LT24_RS),
        .LT24_RESETn (LT24_RESETn),
        .LT24_D      (LT24_D),
        .LT24_LCD_ON (LT24_LCD_ON)
    );

    always #5 clock = ~clock;

    // Record (RS,D) once per word, at the first falling clock after WRn rises.
    always @(negedge clock) begin
        if (!prevWrn && LT24_WRn) words.push_back({LT24_RS, LT24_D});
        prevWrn = LT24_WRn;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {LT24_WRn, LT24_RDn, LT24_CSn, LT24_RS, LT24_RESETn, LT24_LCD_ON,
                          pixIf.pixelReady, initDone, LT24_D}, {8'b1111_0000, 16'h0000});
    endtask

    task automatic checkWords(input string tag, input int n);
        checkOutput({tag, "Count"}, words.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < words.size()) checkOutput($sformatf("%s[%0d]", tag, i), words[i], expWords[i]);
        end
    endtask

    task automatic setWindowExpect(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        expWords[0]  = 17'h0002A;
        expWords[1]  = 17'h10000;
        expWords[2]  = {1'b1, 8'h00, x};
        expWords[3]  = 17'h10000;
        expWords[4]  = 17'h100EF;
        expWords[5]  = 17'h0002B;
        expWords[6]  = {1'b1, 15'h0000, y[8]};
        expWords[7]  = {1'b1, 8'h00, y[7:0]};
        expWords[8]  = 17'h10001;
        expWords[9]  = 17'h1003F;
        expWords[10] = 17'h0002C;
        expWords[11] = {1'b1, d};
    endtask

    task automatic releaseAndInit(input string tag);
        int lowCount;
        int waitClk;
        @(negedge clock);
        words.delete();
        resetApp = 1'b0;
        lowCount = 0;
        #1;
        while (LT24_RESETn == 1'b0 && lowCount < 100) begin
            lowCount++;
            @(negedge clock);
            #1;
        end
        checkOutput({tag, "ResetLowClocks"}, lowCount, 4);
        waitClk = 0;
        while (!initDone && waitClk < 1000) begin
            @(negedge clock);
            waitClk++;
        end
        checkOutput({tag, "InitDone"}, initDone, 1);
        checkOutput({tag, "LcdOnReadyCs"}, {LT24_LCD_ON, pixIf.pixelReady, LT24_CSn}, 3'b110);
        for (int i = 0; i < 6; i++) expWords[i] = initWords[i];
        checkWords({tag, "InitWords"}, 6);
    endtask

    // Sends one pixel; returns how many clocks pixelReady stayed low after acceptance.
    task automatic applyStimulus(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                                 input int hold, output int lowClocks);
        int guard;
        guard = 0;
        while (!pixIf.pixelReady && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        words.delete();
        pixIf.xAddr      = x;
        pixIf.yAddr      = y;
        pixIf.pixelData  = d;
        pixIf.pixelWrite = 1'b1;
        @(negedge clock);
        lowClocks = 0;
        while (pixIf.pixelReady == 1'b0 && lowClocks < 200) begin
            if (lowClocks >= hold) pixIf.pixelWrite = 1'b0;
            lowClocks++;
            @(negedge clock);
        end
        pixIf.pixelWrite = 1'b0;
    endtask

    initial begin
        int lc;
        int bad;
        pixIf.xAddr      = '0;
        pixIf.yAddr      = '0;
        pixIf.pixelData  = '0;
        pixIf.pixelWrite = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        checkResetOutputs("resetOutputs");
        releaseAndInit("boot");

        applyStimulus(8'd0, 9'd0, 16'hF800, 0, lc);
        checkOutput("firstPixelBusy", lc, 49);
        setWindowExpect(8'd0, 9'd0, 16'hF800);
        checkWords("firstPixel", 12);

        applyStimulus(8'd1, 9'd0, 16'h07E0, 0, lc);
        checkOutput("seqPixelBusy", lc, 5);
        expWords[0] = 17'h107E0;
        checkWords("seqPixel", 1);

        applyStimulus(8'd0, 9'd5, 16'h1234, 0, lc);
        checkOutput("row5WindowBusy", lc, 49);
        bad = 0;
        for (int x = 1; x < 240; x++) begin
            applyStimulus(8'(x), 9'd5, 16'(x), 0, lc);
            if (lc != 5) bad++;
        end
        checkOutput("row5RunNonSeq", bad, 0);
        applyStimulus(8'd0, 9'd6, 16'h5A5A, 0, lc);
        checkOutput("rowWrapBusy", lc, 5);
        expWords[0] = 17'h15A5A;
        checkWords("rowWrap", 1);

        applyStimulus(8'd10, 9'd10, 16'h0001, 0, lc);
        applyStimulus(8'd50, 9'd20, 16'hABCD, 0, lc);
        checkOutput("jumpBusy", lc, 49);
        setWindowExpect(8'd50, 9'd20, 16'hABCD);
        checkWords("jump", 12);
        bad = 0;
        for (int x = 51; x < 240; x++) begin
            applyStimulus(8'(x), 9'd20, 16'h0F0F, 0, lc);
            if (lc != 5) bad++;
        end
        checkOutput("row20RunNonSeq", bad, 0);
        applyStimulus(8'd50, 9'd21, 16'hC0DE, 0, lc);
        checkOutput("jumpRowWrapBusy", lc, 5);

        applyStimulus(8'd200, 9'd318, 16'h3333, 0, lc);
        checkOutput("frameWindowBusy", lc, 49);
        setWindowExpect(8'd200, 9'd318, 16'h3333);
        checkWords("frameWindow", 12);
        bad = 0;
        for (int y = 318; y <= 319; y++) begin
            for (int x = 200; x < 240; x++) begin
                if (!(y == 318 && x == 200)) begin
                    applyStimulus(8'(x), 9'(y), 16'h4444, 0, lc);
                    if (lc != 5) bad++;
                end
            end
        end
        checkOutput("frameRunNonSeq", bad, 0);
        applyStimulus(8'd200, 9'd318, 16'h7777, 0, lc);
        checkOutput("frameWrapBusy", lc, 5);
        expWords[0] = 17'h17777;
        checkWords("frameWrap", 1);

        applyStimulus(8'd201, 9'd318, 16'h8888, 3, lc);
        checkOutput("heldWriteBusy", lc, 5);
        repeat (10) @(negedge clock);
        checkOutput("heldWriteWords", words.size(), 1);
        checkOutput("heldWriteReady", pixIf.pixelReady, 1);

        applyStimulus(8'd240, 9'd0, 16'hFFFF, 0, lc);
        checkOutput("xRangeBusy", lc, 1);
        checkOutput("xRangeWords", words.size(), 0);
        applyStimulus(8'd0, 9'd320, 16'hFFFF, 0, lc);
        checkOutput("yRangeBusy", lc, 1);
        checkOutput("yRangeWords", words.size(), 0);
        applyStimulus(8'd202, 9'd318, 16'h9999, 0, lc);
        checkOutput("afterDropSeqBusy", lc, 5);

        pixIf.xAddr      = 8'd0;
        pixIf.yAddr      = 9'd0;
        pixIf.pixelData  = 16'h1111;
        pixIf.pixelWrite = 1'b1;
        @(negedge clock);
        pixIf.pixelWrite = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("midTxnBusy", {LT24_CSn, pixIf.pixelReady}, 2'b00);
        resetApp = 1'b1;
        #1;
        checkResetOutputs("midTxnResetOutputs");
        repeat (2) @(negedge clock);
        releaseAndInit("reinit");
        applyStimulus(8'd203, 9'd318, 16'h2222, 0, lc);
        checkOutput("reinitWindowBusy", lc, 49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
